l_function_divider: RTL and testbench
=====================================

Name: l_function_divider

Overview:
- Decryption-side counterpart of the vote encryption path.
- Computes the Paillier L function, L(x) = (x - 1) / n, on x = c^lambda mod n^2 streamed in block-serially, LSB block first, from the exponentiator.
- Uses word-serial exact (Hensel) division by odd n: no trial division, one REGISTER_SIZE x REGISTER_SIZE multiplier.
- Quotient is streamed out LSB block first to the downstream mu-multiply / Montgomery stage.

Parameters:
- REGISTER_SIZE, 32: block width W in bits.
- BITS_IN_NUM, 4096: bit width of n; quotient width.
- NB_N (localparam): BITS_IN_NUM/REGISTER_SIZE; n and quotient blocks.
- NB_X (localparam): 2*BITS_IN_NUM/REGISTER_SIZE; x blocks.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous, active-low reset.
- valid_in  in  1  x_block_in valid.
- x_block_in  in  W  x block, LSB block first.
- ready_out  out  1  block accepts x blocks.
- n_block_in  in  W  current n block; top level advances on consumed_n_out and wraps after NB_N.
- consumed_n_out  out  1  one-cycle pulse; n_block_in used this cycle.
- n_inv_word_in  in  W  constant n^-1 mod 2^W; held stable for the whole operation.
- valid_out  out  1  data_out holds a quotient block.
- data_out  out  W  quotient block, LSB first.
- final_out  out  1  high with the last quotient block.

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; ready_out=1; valid_out=0; consumed_n_out=0; final_out=0; data_out=0; counters, borrow and carry cleared.
- Reset mid-operation aborts immediately; no further outputs. Top level must reset its n pointer on the same reset.
- Storage: NB_N-word dividend buffer d[0..NB_N-1], as a register array with combinational read.
- IDLE/LOAD (ready_out=1):
  - Each valid_in beat accepts one x block; load counter k counts 0..NB_X-1.
  - Beat k: d[k] = (x_k - 1(k==0 only) - borrow) mod 2^W; borrow updated.
  - Blocks with k >= NB_N are counted and discarded; exactness makes them irrelevant.
  - After beat NB_X-1: ready_out falls the next cycle; go to QWORD with i=0.
  - valid_in while ready_out=0 is ignored.
- QWORD, one cycle:
  - q = (d[i] * n_inv_word_in) mod 2^W, registered into q_reg.
  - Same cycle: data_out=q, valid_out=1, final_out=(i==NB_N-1).
  - Carry c cleared; n index j=0; go to MAC.
  - No backpressure: downstream must accept every valid_out beat.
- MAC, NB_N cycles, j = 0..NB_N-1:
  - consumed_n_out=1 every cycle.
  - p = q_reg*n_block_in + c, 2W+1 bits.
  - If i+j < NB_N: d[i+j] <= (d[i+j] - p) mod 2^W. Otherwise no write.
  - c <= (p - d[i+j] + 2^W - 1) >> W.
  - Exactly NB_N consumes per iteration, including the last, so the top-level n pointer stays aligned.
  - After j=NB_N-1: if i==NB_N-1 go to IDLE, else i++ and go to QWORD.
- Latency: first quotient block 1 cycle after the last x beat. Quotient blocks are spaced NB_N+1 cycles apart. Total is NB_X + NB_N*(NB_N+1) cycles.
- Input precondition: x ≡ 1 mod n and x < n^2. Otherwise the output is defined only as ((x-1)*n^-1) mod 2^BITS_IN_NUM.

Optional Feature:
- Macro: L_UNDERFLOW_CHECK_EN.
- Enabled:
  - Adds output err_out (1 bit), reset 0.
  - err_out is set when the load-phase borrow is still 1 after beat NB_X-1, meaning x==0.
  - err_out is sticky until the next accepted first x block.
  - Quotient stream still runs.
- Disabled: no err_out port, no extra logic.

Decomposition:
- Shared package paillier_pkg:
  - REGISTER_SIZE default and NB_N/NB_X derivation functions.
  - State enum {IDLE, LOAD, QWORD, MAC}.
  - Word typedef word_t.
- One sub-module: word_mac_sub. Combinational W x W multiply, add carry, subtract d word; outputs the new d word and next carry.
- Control FSM and buffer stay in the top module.

Test Plan:
All tests use REGISTER_SIZE=8 and BITS_IN_NUM=16, so NB_N=2 and NB_X=4.
- n=0x0023, n_inv=0x8B, x=0x000000B0 -> data_out 0x05 then 0x00 (final_out with 0x00); 4 consumes per operation.
- n=0xFFF1, n_inv=0x11, x=1+0x1234*0xFFF1 -> 0x34 then 0x12. Check spacing of 3 cycles and first output 1 cycle after the last x beat.
- x=0x00000001, n=0xFFF1 -> 0x00, 0x00; err_out stays 0.
- Drop rst_in during the second MAC phase -> all outputs 0 within the same cycle; a following valid x=0xB0 case reproduces the first test's result.
- With L_UNDERFLOW_CHECK_EN, x=0x00000000 -> err_out=1 after the last x beat, cleared on the next accepted first block.
- Two back-to-back operations, valid_in held high, plus valid_in asserted during MAC -> beats during MAC ignored; both quotients correct.

Source files
------------

// File: rtl/paillier_pkg.sv
// Shared Paillier datapath definitions: word width default, block-count helpers, FSM states.
package paillier_pkg;

  localparam int unsigned REGISTER_SIZE_DEFAULT = 32;

  typedef logic [REGISTER_SIZE_DEFAULT-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    QWORD = 2'd2,
    MAC   = 2'd3
  } state_e;

  // Number of W-bit blocks in an n-sized operand.
  function automatic int unsigned nb_n(input int unsigned bits, input int unsigned w);
    return bits / w;
  endfunction

  // Number of W-bit blocks in an n^2-sized operand.
  function automatic int unsigned nb_x(input int unsigned bits, input int unsigned w);
    return (2 * bits) / w;
  endfunction

endpackage

// File: rtl/word_mac_sub.sv
// One Hensel-division step on a single word: d - (q*n + carry), with the borrow-style carry out.
module word_mac_sub #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] n_word,
  input  logic [W:0]   carry,
  input  logic [W-1:0] d_word,
  output logic [W-1:0] d_new,
  output logic [W:0]   carry_next
);

  localparam int unsigned PW = 2 * W + 1;

  logic [PW-1:0] prod;
  logic [PW-1:0] p;
  logic [PW-1:0] t;

  assign prod = PW'(q) * PW'(n_word);
  assign p    = prod + PW'(carry);
  // p + (2^W - 1 - d) never goes negative, so the ceiling of (p - d) / 2^W is a plain shift
  assign t    = p + {{(W+1){1'b0}}, ~d_word};

  assign d_new      = d_word - W'(p);
  assign carry_next = (W+1)'(t >> W);

endmodule

// File: rtl/l_function_divider.sv
// Paillier L(x) = (x - 1) / n by word-serial exact (Hensel) division, block-serial in and out.
// Optional build macro L_UNDERFLOW_CHECK_EN adds err_out, flagging x == 0.
module l_function_divider
  import paillier_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = REGISTER_SIZE_DEFAULT,
  parameter int unsigned BITS_IN_NUM   = 4096
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] x_block_in,
  output logic                     ready_out,
  input  logic [REGISTER_SIZE-1:0] n_block_in,
  output logic                     consumed_n_out,
  input  logic [REGISTER_SIZE-1:0] n_inv_word_in,
  output logic                     valid_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     final_out
`ifdef L_UNDERFLOW_CHECK_EN
  ,
  output logic                     err_out
`endif
);

  localparam int unsigned W    = REGISTER_SIZE;
  localparam int unsigned NB_N = nb_n(BITS_IN_NUM, REGISTER_SIZE);
  localparam int unsigned NB_X = nb_x(BITS_IN_NUM, REGISTER_SIZE);
  localparam int unsigned KW   = (NB_X > 1) ? $clog2(NB_X) : 1;
  localparam int unsigned IW   = (NB_N > 1) ? $clog2(NB_N) : 1;

  state_e state_q, state_d;

  logic [KW-1:0] k_q;
  logic [IW-1:0] i_q;
  logic [IW-1:0] j_q;
  logic          borrow_q;
  logic [W:0]    c_q;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  d_q [NB_N];

  logic          beat_c;
  logic          load_last_c;
  logic          load_keep_c;
  logic          load_sub_c;
  logic [W:0]    load_diff_c;
  logic          mac_last_c;
  logic          iter_last_c;
  logic [IW:0]   idx_c;
  logic          idx_in_rng_c;
  logic [W-1:0]  d_rd_c;
  logic [W-1:0]  q_c;
  logic [W-1:0]  mac_d_c;
  logic [W:0]    mac_c_c;

  assign beat_c       = valid_in & ready_out;
  assign load_last_c  = beat_c & (k_q == KW'(NB_X - 1));
  assign load_keep_c  = (k_q < KW'(NB_N));
  assign load_sub_c   = (k_q == '0) | borrow_q;
  assign load_diff_c  = {1'b0, x_block_in} - (W+1)'(load_sub_c);
  assign mac_last_c   = (j_q == IW'(NB_N - 1));
  assign iter_last_c  = (i_q == IW'(NB_N - 1));
  assign idx_c        = (IW+1)'(i_q) + (IW+1)'(j_q);
  assign idx_in_rng_c = (idx_c < (IW+1)'(NB_N));
  // Words above the buffer only feed carries into discarded positions, so read them as zero
  assign d_rd_c       = idx_in_rng_c ? d_q[IW'(idx_c)] : '0;
  assign q_c          = W'(d_q[i_q] * n_inv_word_in);

  // n_block_in is used in every MAC cycle, so the consume strobe must be coincident with it
  assign consumed_n_out = (state_q == MAC);

  word_mac_sub #(
    .W(W)
  ) u_word_mac (
    .q          (q_reg),
    .n_word     (n_block_in),
    .carry      (c_q),
    .d_word     (d_rd_c),
    .d_new      (mac_d_c),
    .carry_next (mac_c_c)
  );

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat_c) state_d = LOAD;
      LOAD:    if (load_last_c) state_d = QWORD;
      QWORD:   state_d = MAC;
      MAC:     if (mac_last_c) state_d = iter_last_c ? IDLE : QWORD;
      default: state_d = IDLE;
    endcase
  end

  // Dividend buffer, counters and registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ready_out <= 1'b1;
      valid_out <= 1'b0;
      final_out <= 1'b0;
      data_out  <= '0;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      borrow_q  <= 1'b0;
      c_q       <= '0;
      q_reg     <= '0;
      for (int unsigned b = 0; b < NB_N; b++) d_q[b] <= '0;
    end else begin
      valid_out <= 1'b0;
      final_out <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (beat_c) begin
            if (load_keep_c) d_q[IW'(k_q)] <= load_diff_c[W-1:0];
            borrow_q <= load_diff_c[W];
            if (load_last_c) begin
              k_q       <= '0;
              i_q       <= '0;
              ready_out <= 1'b0;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        QWORD: begin
          q_reg     <= q_c;
          data_out  <= q_c;
          valid_out <= 1'b1;
          final_out <= iter_last_c;
          c_q       <= '0;
          j_q       <= '0;
        end
        MAC: begin
          if (idx_in_rng_c) d_q[IW'(idx_c)] <= mac_d_c;
          c_q <= mac_c_c;
          if (mac_last_c) begin
            j_q <= '0;
            if (iter_last_c) begin
              i_q       <= '0;
              borrow_q  <= 1'b0;
              ready_out <= 1'b1;
            end else begin
              i_q <= i_q + IW'(1);
            end
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef L_UNDERFLOW_CHECK_EN
  // Final load borrow means x - 1 wrapped, i.e. x == 0; sticky until the next operation starts
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      err_out <= 1'b0;
    end else if (beat_c) begin
      if (load_last_c)    err_out <= load_diff_c[W];
      else if (k_q == '0) err_out <= 1'b0;
    end
  end
`else
  // Underflow flag not built.
`endif

endmodule

// File: tb/tb_l_function_divider.sv
// Directed bench for l_function_divider at W=8, n of 16 bits (NB_N=2, NB_X=4).
module tb_l_function_divider;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] x_block_in = 8'h00;
  logic       ready_out;
  logic [7:0] n_block_in;
  logic       consumed_n_out;
  logic [7:0] n_inv_word_in = 8'h00;
  logic       valid_out;
  logic [7:0] data_out;
  logic       final_out;
`ifdef L_UNDERFLOW_CHECK_EN
  logic       err_out;
  logic       err_first;
`endif

  l_function_divider #(
    .REGISTER_SIZE(8),
    .BITS_IN_NUM  (16)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (valid_in),
    .x_block_in    (x_block_in),
    .ready_out     (ready_out),
    .n_block_in    (n_block_in),
    .consumed_n_out(consumed_n_out),
    .n_inv_word_in (n_inv_word_in),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .final_out     (final_out)
`ifdef L_UNDERFLOW_CHECK_EN
    ,
    .err_out       (err_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // n pointer as the surrounding top level would keep it
  logic [15:0] n_val = 16'h0023;
  logic        n_ptr;
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)             n_ptr <= 1'b0;
    else if (consumed_n_out) n_ptr <= ~n_ptr;
  end
  assign n_block_in = n_ptr ? n_val[15:8] : n_val[7:0];

  typedef struct packed {
    logic [7:0]  data;
    logic        fin;
    logic [31:0] cyc;
  } out_t;

  out_t        outq[$];
  int unsigned cons_cnt = 0;
  always @(negedge clk_in) begin
    if (valid_out) outq.push_back({data_out, final_out, cyc});
    if (consumed_n_out) cons_cnt++;
  end

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned last_beat = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_x(input logic [31:0] x, input bit hold);
    for (int b = 0; b < 4; b++) begin
      int g = 0;
      while (!ready_out && g < 200) begin
        tick(1);
        g++;
      end
      if (!ready_out) begin
        check_eq("ready_wait", 32'(ready_out), 32'd1);
        valid_in = 1'b0;
        return;
      end
      x_block_in = 8'(x >> (8 * b));
      valid_in   = 1'b1;
      tick(1);
`ifdef L_UNDERFLOW_CHECK_EN
      if (b == 0) err_first = err_out;
`endif
    end
    last_beat = cyc;
    if (hold) x_block_in = 8'hEE;
    else      valid_in   = 1'b0;
  endtask

  task automatic wait_outs(input int cnt);
    int g = 0;
    while (outq.size() < cnt && g < 100) begin
      tick(1);
      g++;
    end
    if (outq.size() < cnt) check_eq("out_timeout", 32'(outq.size()), 32'(cnt));
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_d, input logic exp_f,
                           output int unsigned c);
    out_t o;
    c = 0;
    if (outq.size() == 0) begin
      check_eq({tag, "_missing"}, 32'd0, 32'd1);
      return;
    end
    o = outq.pop_front();
    check_eq({tag, "_data"}, 32'(o.data), 32'(exp_d));
    check_eq({tag, "_final"}, 32'(o.fin), 32'(exp_f));
    c = o.cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, c1, base;
    n_inv_word_in = 8'h8B;
    tick(3);
    check_eq("rst_ready", 32'(ready_out), 32'd1);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_final", 32'(final_out), 32'd0);
    check_eq("rst_consumed", 32'(consumed_n_out), 32'd0);
`ifdef L_UNDERFLOW_CHECK_EN
    check_eq("rst_err", 32'(err_out), 32'd0);
`endif
    rst_in = 1'b1;
    tick(1);

    // (0xB0 - 1) / 0x23 = 5
    base = cons_cnt;
    send_x(32'h0000_00B0, 1'b0);
    wait_outs(2);
    pop_check("t1_q0", 8'h05, 1'b0, c0);
    pop_check("t1_q1", 8'h00, 1'b1, c1);
    tick(2);
    check_eq("t1_consumes", cons_cnt - base, 32'd4);
    check_eq("t1_ready", 32'(ready_out), 32'd1);

    // x = 1 + 0x1234*0xFFF1 = 0x1232EEF5, latency and spacing
    n_val = 16'hFFF1;
    n_inv_word_in = 8'h11;
    base = cons_cnt;
    send_x(32'h1232_EEF5, 1'b0);
    wait_outs(2);
    pop_check("t2_q0", 8'h34, 1'b0, c0);
    pop_check("t2_q1", 8'h12, 1'b1, c1);
    check_eq("t2_latency", c0 - last_beat, 32'd1);
    check_eq("t2_spacing", c1 - c0, 32'd3);
    tick(2);
    check_eq("t2_consumes", cons_cnt - base, 32'd4);

    // x = 1 gives zero quotient
    send_x(32'h0000_0001, 1'b0);
    wait_outs(2);
    pop_check("t3_q0", 8'h00, 1'b0, c0);
    pop_check("t3_q1", 8'h00, 1'b1, c1);
`ifdef L_UNDERFLOW_CHECK_EN
    check_eq("t3_err", 32'(err_out), 32'd0);
`endif

    // Abort during the second MAC phase
    send_x(32'h1232_EEF5, 1'b0);
    wait_outs(2);
    rst_in = 1'b0;
    #1;
    check_eq("t4_abort_valid", 32'(valid_out), 32'd0);
    check_eq("t4_abort_consumed", 32'(consumed_n_out), 32'd0);
    check_eq("t4_abort_data", 32'(data_out), 32'd0);
    check_eq("t4_abort_final", 32'(final_out), 32'd0);
    check_eq("t4_abort_ready", 32'(ready_out), 32'd1);
    pop_check("t4_pre_q0", 8'h34, 1'b0, c0);
    pop_check("t4_pre_q1", 8'h12, 1'b1, c1);
    tick(2);
    rst_in = 1'b1;
    n_val = 16'h0023;
    n_inv_word_in = 8'h8B;
    tick(3);
    check_eq("t4_no_output", 32'(outq.size()), 32'd0);
    base = cons_cnt;
    send_x(32'h0000_00B0, 1'b0);
    wait_outs(2);
    pop_check("t4_q0", 8'h05, 1'b0, c0);
    pop_check("t4_q1", 8'h00, 1'b1, c1);
    tick(2);
    check_eq("t4_consumes", cons_cnt - base, 32'd4);

`ifdef L_UNDERFLOW_CHECK_EN
    // x = 0 flags underflow until the next first block
    send_x(32'h0000_0000, 1'b0);
    check_eq("t5_err_set", 32'(err_out), 32'd1);
    wait_outs(2);
    void'(outq.pop_front());
    void'(outq.pop_front());
    tick(2);
    check_eq("t5_err_sticky", 32'(err_out), 32'd1);
    send_x(32'h0000_00B0, 1'b0);
    check_eq("t5_err_clear", 32'(err_first), 32'd0);
    wait_outs(2);
    pop_check("t5_q0", 8'h05, 1'b0, c0);
    pop_check("t5_q1", 8'h00, 1'b1, c1);
`endif

    // Back-to-back with valid_in held high through MAC; 0x484 - 1 = 0x21 * 0x23
    tick(2);
    base = cons_cnt;
    send_x(32'h0000_00B0, 1'b1);
    send_x(32'h0000_0484, 1'b1);
    valid_in = 1'b0;
    wait_outs(4);
    pop_check("t6_a_q0", 8'h05, 1'b0, c0);
    pop_check("t6_a_q1", 8'h00, 1'b1, c1);
    pop_check("t6_b_q0", 8'h21, 1'b0, c0);
    pop_check("t6_b_q1", 8'h00, 1'b1, c1);
    tick(2);
    check_eq("t6_consumes", cons_cnt - base, 32'd8);
    check_eq("t6_extra_out", 32'(outq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
    $finish;
  end

endmodule
